// File: rtl/wb_pkg.sv
// wb_pkg: constants and types shared by the writeback/commit stage slice
package wb_pkg;
    localparam int WB_XLEN  = 32;
    localparam int WB_RA_W  = 5;
    localparam int WB_TI_W  = 4;
    localparam int WB_CSR_W = 14;
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;
    localparam logic [5:0] ECODE_IPE  = 6'h0e;
    localparam logic [5:0] ECODE_TLBR = 6'h3f;
    localparam logic [3:0] TLBOP_SRCH = 4'b0001;
    localparam logic [3:0] TLBOP_RD   = 4'b0010;
    localparam logic [3:0] TLBOP_WR   = 4'b0100;
    localparam logic [3:0] TLBOP_FILL = 4'b1000;
    localparam logic [13:0] CSR_CRMD      = 14'h000;
    localparam logic [13:0] CSR_PRMD      = 14'h001;
    localparam logic [13:0] CSR_EUEN      = 14'h002;
    localparam logic [13:0] CSR_ECFG      = 14'h004;
    localparam logic [13:0] CSR_ESTAT     = 14'h005;
    localparam logic [13:0] CSR_ERA       = 14'h006;
    localparam logic [13:0] CSR_BADV      = 14'h007;
    localparam logic [13:0] CSR_EENTRY    = 14'h00c;
    localparam logic [13:0] CSR_TLBIDX    = 14'h010;
    localparam logic [13:0] CSR_TLBEHI    = 14'h011;
    localparam logic [13:0] CSR_TLBELO0   = 14'h012;
    localparam logic [13:0] CSR_TLBELO1   = 14'h013;
    localparam logic [13:0] CSR_ASID      = 14'h018;
    localparam logic [13:0] CSR_SAVE0     = 14'h030;
    localparam logic [13:0] CSR_TID       = 14'h040;
    localparam logic [13:0] CSR_TCFG      = 14'h041;
    localparam logic [13:0] CSR_TVAL      = 14'h042;
    localparam logic [13:0] CSR_TICLR     = 14'h044;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h088;
    localparam logic [13:0] CSR_DMW0      = 14'h180;
    localparam logic [13:0] CSR_DMW1      = 14'h181;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} tlb_state_t;
    // tlbrd/tlbwr/tlbfill change translation state, so younger fetches must be redone
    function automatic logic is_refetch_op(input logic [3:0] op);
        return |(op & (TLBOP_RD | TLBOP_WR | TLBOP_FILL));
    endfunction
endpackage

// File: rtl/wb_commit_stage_if.sv
// wb_commit_stage_if: MEM->WB instruction bus with allowin handshake
interface wb_commit_stage_if #(
    parameter int XLEN  = wb_pkg::WB_XLEN,
    parameter int RA_W  = wb_pkg::WB_RA_W,
    parameter int TI_W  = wb_pkg::WB_TI_W,
    parameter int CSR_W = wb_pkg::WB_CSR_W
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic             in_gr_we;
    logic [RA_W-1:0]  in_dest;
    logic [XLEN-1:0]  in_result;
    logic             in_csr_re;
    logic             in_csr_we;
    logic [CSR_W-1:0] in_csr_num;
    logic [XLEN-1:0]  in_csr_wmask;
    logic [XLEN-1:0]  in_csr_wvalue;
    logic             in_ex;
    logic [5:0]       in_ecode;
    logic [8:0]       in_esubcode;
    logic [XLEN-1:0]  in_badv;
    logic             in_ertn;
    logic             in_refetch;
    logic [3:0]       in_tlb_op;
    logic             in_srch_hit;
    logic [TI_W-1:0]  in_srch_idx;
    modport master (
        output in_valid, in_pc, in_gr_we, in_dest, in_result, in_csr_re, in_csr_we,
               in_csr_num, in_csr_wmask, in_csr_wvalue, in_ex, in_ecode, in_esubcode,
               in_badv, in_ertn, in_refetch, in_tlb_op, in_srch_hit, in_srch_idx,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_pc, in_gr_we, in_dest, in_result, in_csr_re, in_csr_we,
               in_csr_num, in_csr_wmask, in_csr_wvalue, in_ex, in_ecode, in_esubcode,
               in_badv, in_ertn, in_refetch, in_tlb_op, in_srch_hit, in_srch_idx,
        output in_ready
    );
endinterface

// File: rtl/wb_tlb_seq.sv
// wb_tlb_seq: steps a TLB op through request/done and qualifies when the stage may commit
module wb_tlb_seq import wb_pkg::*; (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic tlb_any,
    input  logic ex,
    input  logic tlb_done,
    output logic tlb_req,
    output logic go
);
    tlb_state_t state, state_nx;
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? ((valid && tlb_any && !ex) ? REQ : IDLE)
                 : state == REQ  ? WAIT
                 : tlb_done      ? IDLE : WAIT;
        tlb_req  = state == REQ;
        go       = ex | (state == IDLE && !tlb_any) | (state == WAIT && tlb_done);
    end
endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: last pipeline stage; retires one instruction, writes the GPR file,
// drives CSR access, exception/ertn commit, flush and multi-cycle TLB operations
module wb_commit_stage import wb_pkg::*; #(
    parameter  int XLEN   = WB_XLEN,
    parameter  int NREG   = 32,
    parameter  int TLBNUM = 16,
    parameter  int CSR_W  = WB_CSR_W,
    localparam int RA_W   = $clog2(NREG),
    localparam int TI_W   = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              reset,
    wb_commit_stage_if.slave  bus,
    output logic              csr_re,
    output logic              csr_we,
    output logic [CSR_W-1:0]  csr_num,
    output logic [XLEN-1:0]   csr_wmask,
    output logic [XLEN-1:0]   csr_wvalue,
    input  logic [XLEN-1:0]   csr_rvalue,
    output logic              tlb_req,
    output logic [3:0]        tlb_op,
    output logic              tlb_srch_hit,
    output logic [TI_W-1:0]   tlb_srch_idx,
    input  logic              tlb_done,
    output logic              ex_commit,
    output logic              ertn_commit,
    output logic [XLEN-1:0]   ex_pc,
    output logic [5:0]        ex_ecode,
    output logic [8:0]        ex_esubcode,
    output logic [XLEN-1:0]   ex_badv,
    output logic              flush,
    output logic [XLEN-1:0]   refetch_pc,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [63:0]       retire_cnt,
    output logic [XLEN-1:0]   debug_wb_pc,
    output logic [XLEN/8-1:0] debug_wb_rf_we,
    output logic [RA_W-1:0]   debug_wb_rf_wnum,
    output logic [XLEN-1:0]   debug_wb_rf_wdata
);
    logic            valid, gr_we, csr_re_r, csr_we_r, ex, ertn, refetch;
    logic [XLEN-1:0] result;
    logic            go, commit, load, tlb_any;
    assign tlb_any      = |tlb_op;
    assign commit       = valid & go;
    assign load         = bus.in_valid & bus.in_ready;
    assign bus.in_ready = ~valid | commit;
    always_ff @(posedge clk) begin
        if (reset) begin
            valid      <= 1'b0;
            retire_cnt <= '0;
        end else begin
            valid      <= bus.in_ready ? bus.in_valid & ~flush : valid;
            retire_cnt <= retire_cnt + 64'(commit & ~ex);
        end
        if (load) begin
            ex_pc        <= bus.in_pc;
            gr_we        <= bus.in_gr_we;
            rf_waddr     <= bus.in_dest;
            result       <= bus.in_result;
            csr_re_r     <= bus.in_csr_re;
            csr_we_r     <= bus.in_csr_we;
            csr_num      <= bus.in_csr_num;
            csr_wmask    <= bus.in_csr_wmask;
            csr_wvalue   <= bus.in_csr_wvalue;
            ex           <= bus.in_ex;
            ex_ecode     <= bus.in_ecode;
            ex_esubcode  <= bus.in_esubcode;
            ex_badv      <= bus.in_badv;
            ertn         <= bus.in_ertn;
            refetch      <= bus.in_refetch;
            tlb_op       <= bus.in_tlb_op;
            tlb_srch_hit <= bus.in_srch_hit;
            tlb_srch_idx <= bus.in_srch_idx;
        end
    end
    wb_tlb_seq u_seq (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .tlb_any  (tlb_any),
        .ex       (ex),
        .tlb_done (tlb_done),
        .tlb_req  (tlb_req),
        .go       (go)
    );
    // an exception suppresses every architectural side effect of its instruction
    assign csr_re            = valid & csr_re_r;
    assign csr_we            = commit & csr_we_r & ~ex;
    assign ex_commit         = commit & ex;
    assign ertn_commit       = commit & ertn & ~ex;
    assign flush             = commit & (ex | ertn | refetch | is_refetch_op(tlb_op));
    assign refetch_pc        = ex_pc + XLEN'(4);
    assign rf_we             = commit & gr_we & ~ex;
    assign rf_wdata          = csr_re ? csr_rvalue : result;
    assign debug_wb_pc       = ex_pc;
    assign debug_wb_rf_we    = {(XLEN/8){rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage: directed and random stimulus checked against a transaction-level
// model that tracks the resident instruction, its age and its scheduled TLB completion
module tb_wb_commit_stage;
    import wb_pkg::*;
    localparam int XLEN = 32, RA_W = 5, TI_W = 4, CSR_W = 14;
    typedef struct {
        logic [XLEN-1:0]  pc, result, wmask, wvalue, badv;
        logic             gr_we, csr_re, csr_we, ex, ertn, refetch, hit;
        logic [RA_W-1:0]  dest;
        logic [CSR_W-1:0] num;
        logic [5:0]       ecode;
        logic [8:0]       esub;
        logic [3:0]       op;
        logic [TI_W-1:0]  idx;
        int               lat;
    } instr_t;
    logic clk = 1'b0;
    logic reset, tlb_done;
    logic [XLEN-1:0] csr_rvalue;
    logic csr_re, csr_we, tlb_req, tlb_srch_hit, ex_commit, ertn_commit, flush, rf_we;
    logic [CSR_W-1:0] csr_num;
    logic [XLEN-1:0] csr_wmask, csr_wvalue, ex_pc, ex_badv, refetch_pc, rf_wdata;
    logic [XLEN-1:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0] tlb_op, debug_wb_rf_we;
    logic [TI_W-1:0] tlb_srch_idx;
    logic [5:0] ex_ecode;
    logic [8:0] ex_esubcode;
    logic [RA_W-1:0] rf_waddr, debug_wb_rf_wnum;
    logic [63:0] retire_cnt;
    always #5 clk = ~clk;
    wb_commit_stage_if bus ();
    wb_commit_stage dut (
        .clk(clk), .reset(reset), .bus(bus),
        .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
        .tlb_req(tlb_req), .tlb_op(tlb_op), .tlb_srch_hit(tlb_srch_hit),
        .tlb_srch_idx(tlb_srch_idx), .tlb_done(tlb_done),
        .ex_commit(ex_commit), .ertn_commit(ertn_commit), .ex_pc(ex_pc),
        .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode), .ex_badv(ex_badv),
        .flush(flush), .refetch_pc(refetch_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_cnt(retire_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );
    int checks = 0, errors = 0;
    bit occ = 0, rst_i = 1, v_i = 0, e_commit = 0, e_flush = 0, e_ready = 1;
    bit done_en = 0, done_val = 0, rv_en = 0;
    logic [XLEN-1:0] rv_val = '0;
    logic [63:0] cnt = '0;
    instr_t cur, nx;
    int age = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic instr_t rand_instr();
        instr_t t;
        t.pc      = $urandom & 32'hffff_fffc;
        t.result  = $urandom;
        t.wmask   = $urandom;
        t.wvalue  = $urandom;
        t.badv    = $urandom;
        t.gr_we   = 1'($urandom);
        t.dest    = 5'($urandom);
        t.num     = 14'($urandom);
        t.csr_re  = $urandom_range(0, 3) == 0;
        t.csr_we  = $urandom_range(0, 3) == 0;
        t.ex      = $urandom_range(0, 7) == 0;
        t.ertn    = $urandom_range(0, 9) == 0;
        t.refetch = $urandom_range(0, 9) == 0;
        t.op      = $urandom_range(0, 2) == 0 ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
        t.ecode   = 6'($urandom);
        t.esub    = 9'($urandom);
        t.hit     = 1'($urandom);
        t.idx     = 4'($urandom);
        t.lat     = $urandom_range(2, 6);
        return t;
    endfunction
    function automatic instr_t plain();
        instr_t t = rand_instr();
        t.csr_re = 0; t.csr_we = 0; t.ex = 0; t.ertn = 0; t.refetch = 0; t.op = '0;
        return t;
    endfunction
    // one clock: retire/load in the model at the edge, drive the next inputs, check mid-cycle
    task automatic step(input bit rst, input bit v, input instr_t t);
        bit tlb;
        logic [XLEN-1:0] wd;
        @(posedge clk);
        if (rst_i) begin
            occ = 0; cnt = '0;
        end else if (e_commit) begin
            if (!cur.ex) cnt = cnt + 64'd1;
            occ = v_i && !e_flush; cur = nx; age = 0;
        end else if (occ) age++;
        else if (v_i) begin
            occ = 1; cur = nx; age = 0;
        end
        #1;
        rst_i = rst; v_i = v; nx = t;
        reset = rst; bus.in_valid = v; bus.in_pc = t.pc; bus.in_gr_we = t.gr_we;
        bus.in_dest = t.dest; bus.in_result = t.result; bus.in_csr_re = t.csr_re;
        bus.in_csr_we = t.csr_we; bus.in_csr_num = t.num; bus.in_csr_wmask = t.wmask;
        bus.in_csr_wvalue = t.wvalue; bus.in_ex = t.ex; bus.in_ecode = t.ecode;
        bus.in_esubcode = t.esub; bus.in_badv = t.badv; bus.in_ertn = t.ertn;
        bus.in_refetch = t.refetch; bus.in_tlb_op = t.op; bus.in_srch_hit = t.hit;
        bus.in_srch_idx = t.idx;
        tlb = occ && cur.op != 0 && !cur.ex;
        tlb_done = done_en ? done_val
                 : tlb ? (age == cur.lat || (age < 2 && $urandom_range(0, 1) == 1))
                 : $urandom_range(0, 1) == 1;
        csr_rvalue = rv_en ? rv_val : $urandom;
        @(negedge clk);
        e_commit = occ && (!tlb || age == cur.lat);
        e_flush  = e_commit && (cur.ex || cur.ertn || cur.refetch || cur.op[3:1] != 0);
        e_ready  = !occ || e_commit;
        check("in_ready", bus.in_ready, e_ready);
        check("tlb_req", tlb_req, occ && tlb && age == 1);
        check("ex_commit", ex_commit, e_commit && cur.ex);
        check("ertn_commit", ertn_commit, e_commit && cur.ertn && !cur.ex);
        check("flush", flush, e_flush);
        check("rf_we", rf_we, e_commit && cur.gr_we && !cur.ex);
        check("csr_we", csr_we, e_commit && cur.csr_we && !cur.ex);
        check("csr_re", csr_re, occ && cur.csr_re);
        check("retire_cnt", retire_cnt, cnt);
        check("dbg_rf_we", debug_wb_rf_we, {4{e_commit && cur.gr_we && !cur.ex}});
        if (occ) begin
            wd = cur.csr_re ? csr_rvalue : cur.result;
            check("rf_waddr", rf_waddr, cur.dest);
            check("rf_wdata", rf_wdata, wd);
            check("dbg_pc", debug_wb_pc, cur.pc);
            check("dbg_wnum", debug_wb_rf_wnum, cur.dest);
            check("dbg_wdata", debug_wb_rf_wdata, wd);
            check("csr_num", csr_num, cur.num);
            check("csr_wmask", csr_wmask, cur.wmask);
            check("csr_wvalue", csr_wvalue, cur.wvalue);
        end
        if (e_commit && cur.ex) begin
            check("ex_pc", ex_pc, cur.pc);
            check("ex_ecode", ex_ecode, cur.ecode);
            check("ex_esubcode", ex_esubcode, cur.esub);
            check("ex_badv", ex_badv, cur.badv);
        end
        if (e_flush && !cur.ex) check("refetch_pc", refetch_pc, cur.pc + 32'd4);
        if (occ && tlb && age == 1) begin
            check("tlb_op", tlb_op, cur.op);
            check("tlb_srch_hit", tlb_srch_hit, cur.hit);
            check("tlb_srch_idx", tlb_srch_idx, cur.idx);
        end
    endtask
    task automatic issue(input instr_t t);
        step(0, 1, t);
        for (int k = 0; k < 20 && !e_ready; k++) step(0, 1, t);
        check("issue_ready", bus.in_ready, 1'b1);
    endtask
    initial begin
        instr_t t;
        reset = 1; bus.in_valid = 0; tlb_done = 0; csr_rvalue = '0;
        step(1, 0, plain());
        check("reset_ready", bus.in_ready, 1'b1);
        step(0, 0, plain());
        t = plain(); t.pc = 32'h1c00_0000; t.gr_we = 1; t.dest = 5'd5; t.result = 32'h1234;
        issue(t);
        t.pc = 32'h1c00_0004;
        issue(t);
        step(0, 0, plain());
        check("add_wdata", rf_wdata, 32'h1234);
        step(0, 0, plain());
        check("add_cnt", retire_cnt, 64'd2);
        t = plain(); t.csr_re = 1; t.num = 14'h5; t.gr_we = 1; t.dest = 5'd9;
        issue(t);
        rv_en = 1; rv_val = 32'hABCD;
        step(0, 0, plain());
        check("csrrd_wdata", rf_wdata, 32'hABCD);
        check("csrrd_csr_we", csr_we, 1'b0);
        rv_en = 0;
        t = plain(); t.ex = 1; t.ecode = ECODE_SYS; t.gr_we = 1; t.csr_we = 1;
        issue(t);
        step(0, 1, plain());
        check("sys_flush", flush, 1'b1);
        check("sys_cnt", retire_cnt, 64'd3);
        step(0, 0, plain());
        t = plain(); t.op = TLBOP_WR; t.lat = 6; t.pc = 32'h1c00_0100;
        issue(t);
        repeat (8) step(0, 0, plain());
        t = plain(); t.op = TLBOP_SRCH; t.hit = 1; t.idx = 4'd7; t.lat = 3;
        issue(t);
        repeat (5) step(0, 0, plain());
        t = plain(); t.op = TLBOP_RD; t.lat = 20;
        issue(t);
        repeat (3) step(0, 0, plain());
        step(1, 0, plain());
        done_en = 1; done_val = 1;
        step(0, 0, plain());
        done_en = 0;
        check("rst_wait_cnt", retire_cnt, 64'd0);
        check("rst_wait_ready", bus.in_ready, 1'b1);
        step(0, 0, plain());
        for (int i = 0; i < 2000; i++) begin
            t = (v_i && !e_ready) ? nx : rand_instr();
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, t);
        end
        repeat (10) step(0, 0, plain());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
